// File: rtl/pipe_ctrl_if.sv
// Stall/flush bus between pipe_ctrl (slave) and the stage/exception logic (master).
interface pipe_ctrl_if #(
   parameter int unsigned NSTAGE = 6,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned CNT_W  = 32
);
   logic [NSTAGE-1:0] stallreq;
   logic              flushreq;
   logic [PC_W-1:0]   flush_pc;
   logic [NSTAGE-1:0] stall;
   logic [NSTAGE-1:0] flush;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              wdog_trip;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output stallreq, flushreq, flush_pc,
      input  stall, flush, redirect_valid, redirect_pc, wdog_trip, stall_cnt, flush_cnt
   );

   modport slave (
      input  stallreq, flushreq, flush_pc,
      output stall, flush, redirect_valid, redirect_pc, wdog_trip, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: thermometer stall vector, registered flush/redirect, stall watchdog.
// Optional saturating perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
   parameter int unsigned NSTAGE = 6,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned WDOG_W = 8,
   parameter int unsigned CNT_W  = 32
) (
   input  logic          clk,
   input  logic          rst,
   pipe_ctrl_if.slave    bus
);

   typedef enum logic {IDLE, FLUSH} state_e;

   localparam logic [NSTAGE-1:0] FLUSH_MASK = {NSTAGE{1'b1}} >> 1;
   localparam logic [WDOG_W-1:0] WDOG_MAX   = '1;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   rpc_q, rpc_d;
   logic              pend_q, pend_d;
   logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
   logic [NSTAGE-1:0] flush_q, flush_d;
   logic              rv_q, rv_d;
   logic [WDOG_W-1:0] wcnt_q, wcnt_d;
   logic              trip_q, trip_d;
   logic [NSTAGE-1:0] therm_c;
   logic [NSTAGE-1:0] stall_c;

   // Every stage at or below the highest requester stalls.
   always_comb begin
      logic acc;
      acc     = 1'b0;
      therm_c = '0;
      for (int j = int'(NSTAGE) - 1; j >= 0; j--) begin
         acc        = acc | bus.stallreq[j];
         therm_c[j] = acc;
      end
   end

   // Flush overrides stall; nothing stalls while in reset.
   assign stall_c = (rst && state_q == IDLE) ? therm_c : '0;

   always_comb begin
      state_d   = state_q;
      rpc_d     = rpc_q;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;
      case (state_q)
         IDLE: begin
            if (bus.flushreq) begin
               state_d = FLUSH;
               rpc_d   = bus.flush_pc;
            end
         end
         FLUSH: begin
            // A request sampled at the exit edge is consumed by one more FLUSH cycle.
            if (bus.flushreq) begin
               pend_d    = 1'b1;
               pend_pc_d = bus.flush_pc;
            end
            if (pend_d) begin
               state_d = FLUSH;
               rpc_d   = pend_pc_d;
               pend_d  = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      flush_d = (state_d == FLUSH) ? FLUSH_MASK : '0;
      rv_d    = (state_d == FLUSH);
   end

   always_comb begin
      wcnt_d = '0;
      if (stall_c[0]) begin
         wcnt_d = (wcnt_q == WDOG_MAX) ? wcnt_q : wcnt_q + WDOG_W'(1);
      end
      trip_d = trip_q | (wcnt_d == WDOG_MAX);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         rpc_q     <= '0;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
         flush_q   <= '0;
         rv_q      <= 1'b0;
         wcnt_q    <= '0;
         trip_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rpc_q     <= rpc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
         flush_q   <= flush_d;
         rv_q      <= rv_d;
         wcnt_q    <= wcnt_d;
         trip_q    <= trip_d;
      end
   end

   assign bus.stall          = stall_c;
   assign bus.flush          = flush_q;
   assign bus.redirect_valid = rv_q;
   assign bus.redirect_pc    = rpc_q;
   assign bus.wdog_trip      = trip_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_c[0] && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (state_q == FLUSH && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.stall_cnt = '0;
   assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (WDOG_W=4, CNT_W=4); perf expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pipe_ctrl_if #(.NSTAGE(6), .PC_W(32), .CNT_W(4)) bus ();

   pipe_ctrl #(.NSTAGE(6), .PC_W(32), .WDOG_W(4), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.stallreq = '0;
      bus.flushreq = 1'b0;
      bus.flush_pc = '0;
      #1;
      chk("rst_stall", 64'(bus.stall), 64'h0);
      chk("rst_flush", 64'(bus.flush), 64'h0);
      chk("rst_rv", 64'(bus.redirect_valid), 64'h0);
      chk("rst_rpc", 64'(bus.redirect_pc), 64'h0);
      chk("rst_trip", 64'(bus.wdog_trip), 64'h0);
      #11 rst = 1'b1;
      cyc();

      // Combinational stall vector, no clock edge in between.
      bus.stallreq = 6'b000100; #1;
      chk("stall_000100", 64'(bus.stall), 64'b000111);
      bus.stallreq = 6'b001000; #1;
      chk("stall_001000", 64'(bus.stall), 64'b001111);
      bus.stallreq = 6'b001100; #1;
      chk("stall_001100", 64'(bus.stall), 64'b001111);
      bus.stallreq = 6'b100000; #1;
      chk("stall_100000", 64'(bus.stall), 64'b111111);
      bus.stallreq = 6'b000000; #1;
      chk("stall_none", 64'(bus.stall), 64'h0);
      chk("idle_flush", 64'(bus.flush), 64'h0);
      chk("idle_rv", 64'(bus.redirect_valid), 64'h0);

      // Flush latency and override of a held stall.
      bus.stallreq = 6'b001000;
      bus.flushreq = 1'b1;
      bus.flush_pc = 32'hBFC00380;
      cyc();
      bus.flushreq = 1'b0;
      bus.flush_pc = 32'h0;
      #1;
      chk("fl_stall", 64'(bus.stall), 64'h0);
      chk("fl_flush", 64'(bus.flush), 64'b011111);
      chk("fl_rv", 64'(bus.redirect_valid), 64'h1);
      chk("fl_rpc", 64'(bus.redirect_pc), 64'hBFC00380);
      cyc();
      chk("post_fl_stall", 64'(bus.stall), 64'b001111);
      chk("post_fl_flush", 64'(bus.flush), 64'h0);
      chk("post_fl_rv", 64'(bus.redirect_valid), 64'h0);

      // Back-to-back flush.
      bus.stallreq = '0;
      bus.flushreq = 1'b1;
      bus.flush_pc = 32'h00001000;
      cyc();
      chk("b2b_rv1", 64'(bus.redirect_valid), 64'h1);
      chk("b2b_rpc1", 64'(bus.redirect_pc), 64'h00001000);
      bus.flush_pc = 32'h00002000;
      cyc();
      bus.flushreq = 1'b0;
      chk("b2b_rv2", 64'(bus.redirect_valid), 64'h1);
      chk("b2b_flush2", 64'(bus.flush), 64'b011111);
      chk("b2b_rpc2", 64'(bus.redirect_pc), 64'h00002000);
      cyc();
      chk("b2b_idle_rv", 64'(bus.redirect_valid), 64'h0);
      chk("b2b_idle_flush", 64'(bus.flush), 64'h0);
      chk("perf_flush_cnt", 64'(bus.flush_cnt), PERF ? 64'd3 : 64'd0);
      chk("perf_stall_cnt1", 64'(bus.stall_cnt), PERF ? 64'd1 : 64'd0);

      // Watchdog: trips after the 15th stalled cycle, then stays set.
      bus.stallreq = 6'b000001;
      for (int i = 0; i < 14; i++) cyc();
      chk("wdog_14", 64'(bus.wdog_trip), 64'h0);
      cyc();
      chk("wdog_15", 64'(bus.wdog_trip), 64'h1);
      chk("perf_stall_sat", 64'(bus.stall_cnt), PERF ? 64'd15 : 64'd0);
      bus.stallreq = '0;
      cyc(); cyc(); cyc();
      chk("wdog_sticky", 64'(bus.wdog_trip), 64'h1);

      // Async reset in the middle of a FLUSH cycle.
      bus.flushreq = 1'b1;
      bus.flush_pc = 32'hDEADBEEF;
      cyc();
      bus.flushreq = 1'b0;
      bus.stallreq = 6'b000100;
      chk("pre_rst_rv", 64'(bus.redirect_valid), 64'h1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_stall", 64'(bus.stall), 64'h0);
      chk("mid_rst_flush", 64'(bus.flush), 64'h0);
      chk("mid_rst_rv", 64'(bus.redirect_valid), 64'h0);
      chk("mid_rst_rpc", 64'(bus.redirect_pc), 64'h0);
      chk("mid_rst_trip", 64'(bus.wdog_trip), 64'h0);
      chk("mid_rst_scnt", 64'(bus.stall_cnt), 64'h0);
      chk("mid_rst_fcnt", 64'(bus.flush_cnt), 64'h0);
      cyc();
      #3 rst = 1'b1;
      #1;
      chk("post_rst_stall", 64'(bus.stall), 64'b000111);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("post_rst_rv", 64'(bus.redirect_valid), 64'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline control unit for the in-order MIPS core; next generation of the fixed six-bit stall controller.
- Takes per-stage stall requests from any of NSTAGE stages and produces the stall vector.
- Adds registered, exception-style pipeline flush with redirect PC, a stall watchdog, and optional saturating performance counters.
- Sits beside the stage modules in the core top; drives the stall bus and the new flush/redirect bus.

Parameters:
- NSTAGE, 6, number of stall-vector bits; bit0 = PC, bit1 = IF, bit2 = ID, bit3 = EX, bit4 = MEM, bit5 = WB.
- PC_W, 32, redirect PC width.
- WDOG_W, 8, watchdog counter width; trip at all-ones.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq  in  NSTAGE  bit k = stage k requests a stall.
- flushreq  in  1  single-cycle flush request from exception logic.
- flush_pc  in  PC_W  redirect target; valid with flushreq.
- stall  out  NSTAGE  stall vector to all stages.
- flush  out  NSTAGE  per-stage flush; stages clear their pipeline registers when set.
- redirect_valid  out  1  PC stage loads redirect_pc this cycle.
- redirect_pc  out  PC_W  registered redirect target.
- wdog_trip  out  1  sticky stall-timeout flag.
- stall_cnt  out  CNT_W  cycles with stall[0]=1 (PIPE_CTRL_PERF_EN only).
- flush_cnt  out  CNT_W  flushes issued (PIPE_CTRL_PERF_EN only).

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM in IDLE, pending flag cleared, counters 0.
- Stall vector (combinational):
  - k = highest index with stallreq[k]=1; stall[j]=1 for j<=k, else 0.
  - No request gives stall = 0.
  - Example: stallreq=000100 gives stall=000111; stallreq=001000 gives stall=001111; stallreq=001100 gives stall=001111.
  - The bubble into stage k+1 is produced by the stages from stall[k]=1, stall[k+1]=0.
- FSM states are IDLE and FLUSH.
- IDLE:
  - flushreq=1 at an edge: latch flush_pc into redirect_pc and go to FLUSH.
  - Latency is exactly one cycle from flushreq to flush output.
- FLUSH (one cycle):
  - flush = all ones except bit NSTAGE-1 (WB commits).
  - redirect_valid=1.
  - stall forced to 0 regardless of stallreq, so flush overrides stall.
  - Next state is IDLE, unless the pending flag is set.
- flushreq while in FLUSH:
  - Set pending and latch the new flush_pc into a pending register.
  - At the FLUSH exit edge: load redirect_pc from the pending register, clear pending, stay in FLUSH one more cycle.
  - Only the most recent pending target is kept.
- Outside FLUSH: flush=0 and redirect_valid=0.
- Watchdog:
  - Counter increments each cycle stall[0]=1 and clears when stall[0]=0 or during FLUSH.
  - On reaching 2^WDOG_W-1, wdog_trip is set; it stays set until reset.
  - The counter holds at the maximum.
- Reset asserted mid-flush: FLUSH is abandoned immediately; no redirect_valid after rst deasserts.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cnt increments each cycle stall[0]=1.
  - flush_cnt increments each cycle in FLUSH.
  - Both saturate at all-ones; reset to 0.
- Undefined: stall_cnt and flush_cnt tied to 0 and no counter flops are generated.

Test Plan:
- Per-stage stall: drive stallreq=000100, then 001000, then 001100 → stall=000111, then 001111, then 001111; flush=0 and redirect_valid=0 throughout.
- Flush latency and override: stallreq=001000 held, pulse flushreq with flush_pc=0xBFC00380 → next cycle stall=000000, flush=011111, redirect_valid=1, redirect_pc=0xBFC00380; following cycle stall=001111, flush=0.
- Back-to-back flush: flushreq with 0x00001000, then flushreq with 0x00002000 on the next cycle → two consecutive FLUSH cycles with redirect_pc 0x00001000 then 0x00002000; then IDLE.
- Watchdog (WDOG_W=4): hold stallreq=000001 for 15 cycles → wdog_trip rises after the 15th cycle; release → wdog_trip stays 1 until rst=0.
- Async reset mid-flush: assert rst=0 between clock edges during FLUSH → all outputs 0 immediately; after rst=1, no redirect_valid pulse.
- Perf counters (PIPE_CTRL_PERF_EN defined, CNT_W=4): 20 stalled cycles plus 3 flushes → stall_cnt=15 (saturated), flush_cnt=3; with the macro undefined both read 0.
